// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave controller.
package wave_pkg;

   typedef enum logic [1:0] {
      SAW       = 2'd0,
      SQUARE    = 2'd1,
      TRIANGLE  = 2'd2,
      RAMP_DOWN = 2'd3
   } wave_e;

   localparam int WAVE_W = 2;

   function automatic wave_e next_wave(input wave_e cur);
      return wave_e'(cur + 2'd1);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Falling-edge detector for an active-low debounced button; one press per low level.
module btn_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   logic hist;

   always_ff @(posedge i_clk) begin
      if (i_rst) hist <= 1'b1;
      else       hist <= i_btn_n;
   end

   assign o_press = ~i_btn_n & hist;

endmodule

// File: rtl/wave_ctrl.sv
// Button-driven wave selector and frequency index feeding a phase accumulator
// with a registered waveform sample stage.
module wave_ctrl
   import wave_pkg::*;
#(
   parameter int ACC_W     = 24,
   parameter int ADDR_W    = 8,
   parameter int NUM_STEPS = 16,
   parameter int INC_UNIT  = 1024
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_mode_n,
   input  logic                         i_up_n,
   input  logic                         i_dn_n,
   input  logic                         i_en,
   output logic [WAVE_W-1:0]            o_wave_sel,
   output logic [$clog2(NUM_STEPS)-1:0] o_freq_idx,
   output logic                         o_wrap,
   output logic [ADDR_W-1:0]            o_sample
);

   localparam int IDX_W = $clog2(NUM_STEPS);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_STEPS - 1);

   logic mode_press, up_press, dn_press;

   btn_edge u_mode (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_mode_n), .o_press(mode_press));
   btn_edge u_up   (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_up_n),   .o_press(up_press));
   btn_edge u_dn   (.i_clk(i_clk), .i_rst(i_rst), .i_btn_n(i_dn_n),   .o_press(dn_press));

   wave_e             wave_sel;
   logic [IDX_W-1:0]  freq_idx;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  inc;
   logic [ACC_W:0]    sum;
   logic [ADDR_W-1:0] phase, tri_v, shape;

   // Increment is derived from the registered index, so a new index
   // takes effect one cycle after it registers.
   assign inc = ACC_W'((32'(freq_idx) + 32'd1) * 32'(INC_UNIT));
   assign sum = {1'b0, acc} + {1'b0, inc};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wave_sel <= SAW;
         freq_idx <= '0;
         acc      <= '0;
         o_wrap   <= 1'b0;
         o_sample <= '0;
      end else begin
         if (mode_press) wave_sel <= next_wave(wave_sel);
         // Simultaneous up and down cancel out.
         if (up_press && !dn_press && freq_idx != IDX_MAX)
            freq_idx <= freq_idx + 1'b1;
         else if (dn_press && !up_press && freq_idx != '0)
            freq_idx <= freq_idx - 1'b1;
         if (i_en) acc <= sum[ACC_W-1:0];
         o_wrap   <= i_en & sum[ACC_W];
         o_sample <= shape;
      end
   end

   assign phase = acc[ACC_W-1 -: ADDR_W];
   assign tri_v = {phase[ADDR_W-2:0], 1'b0};

   always_comb begin
      shape = phase;
      case (wave_sel)
         SAW:       shape = phase;
         SQUARE:    shape = {ADDR_W{phase[ADDR_W-1]}};
         TRIANGLE:  shape = phase[ADDR_W-1] ? ~tri_v : tri_v;
         RAMP_DOWN: shape = ~phase;
         default:   shape = phase;
      endcase
   end

   assign o_wave_sel = wave_sel;
   assign o_freq_idx = freq_idx;

endmodule

// File: tb/tb_wave_ctrl.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares every cycle.
module tb_wave_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_mode_n = 1'b1, i_up_n = 1'b1, i_dn_n = 1'b1, i_en = 1'b0;
   logic [1:0] o_wave_sel;
   logic [3:0] o_freq_idx;
   logic       o_wrap;
   logic [7:0] o_sample;

   wave_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_mode_n(i_mode_n), .i_up_n(i_up_n),
      .i_dn_n(i_dn_n), .i_en(i_en), .o_wave_sel(o_wave_sel),
      .o_freq_idx(o_freq_idx), .o_wrap(o_wrap), .o_sample(o_sample)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int wave;
      int idx;
      int wrap;
      int sample;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference state: plain integers, phase as a number modulo 2^24.
   int    m_wave = 0, m_idx = 0, m_sample = 0, m_wrap = 0;
   longint m_acc = 0;
   bit    m_pm = 1, m_pu = 1, m_pd = 1;
   bit    cur_en = 0;

   function automatic int ref_shape(int p, int w);
      case (w)
         0: return p;
         1: return (p >= 128) ? 255 : 0;
         2: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         default: return 255 - p;
      endcase
   endfunction

   task automatic chk(input string nm, input int got, input int expv);
      tests++;
      if (got != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit mn, input bit un, input bit dn, input bit en);
      bit pm, pu, pd;
      longint inc, s;
      if (rst) begin
         m_wave = 0; m_idx = 0; m_acc = 0; m_wrap = 0; m_sample = 0;
         m_pm = 1; m_pu = 1; m_pd = 1;
      end else begin
         pm = !mn && m_pm;
         pu = !un && m_pu;
         pd = !dn && m_pd;
         m_sample = ref_shape(int'(m_acc / 65536), m_wave);
         inc = longint'(m_idx + 1) * 1024;
         if (en) begin
            s = m_acc + inc;
            m_wrap = (s >= 64'd16777216) ? 1 : 0;
            m_acc = s % 64'd16777216;
         end else begin
            m_wrap = 0;
         end
         if (pm) m_wave = (m_wave + 1) % 4;
         if (pu && !pd)      m_idx = (m_idx < 15) ? m_idx + 1 : 15;
         else if (pd && !pu) m_idx = (m_idx > 0) ? m_idx - 1 : 0;
         m_pm = mn; m_pu = un; m_pd = dn;
      end
   endtask

   task automatic drive(input bit rst, input bit mn, input bit un, input bit dn, input bit en);
      exp_t e;
      @(negedge i_clk);
      i_rst = rst; i_mode_n = mn; i_up_n = un; i_dn_n = dn; i_en = en;
      model_step(rst, mn, un, dn, en);
      e.wave = m_wave; e.idx = m_idx; e.wrap = m_wrap; e.sample = m_sample;
      q.push_back(e);
      @(posedge i_clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 1, 1, cur_en);
   endtask
   task automatic p_mode(); drive(0, 0, 1, 1, cur_en); drive(0, 1, 1, 1, cur_en); endtask
   task automatic p_up();   drive(0, 1, 0, 1, cur_en); drive(0, 1, 1, 1, cur_en); endtask
   task automatic p_dn();   drive(0, 1, 1, 0, cur_en); drive(0, 1, 1, 1, cur_en); endtask

   // Monitor: outputs are valid every cycle; one prediction per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_wave_sel", int'(o_wave_sel), e.wave);
            chk("sb_freq_idx", int'(o_freq_idx), e.idx);
            chk("sb_wrap",     int'(o_wrap),     e.wrap);
            chk("sb_sample",   int'(o_sample),   e.sample);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw, wcyc;
      drive(1, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 0);
      #1;
      chk("rst_sample", int'(o_sample), 0);
      chk("rst_idx", int'(o_freq_idx), 0);

      // Full ramp at idx 0: exactly one wrap, on the 16384th enabled edge.
      cur_en = 1; nw = 0; wcyc = -1;
      for (int i = 0; i < 16384; i++) begin
         drive(0, 1, 1, 1, 1);
         #1;
         if (o_wrap) begin nw++; wcyc = i; end
      end
      chk("ramp_wrap_count", nw, 1);
      chk("ramp_wrap_cycle", wcyc, 16383);

      // Frequency saturation and cancel rules.
      cur_en = 0;
      for (int i = 0; i < 20; i++) p_up();
      #1; chk("idx_sat_hi", int'(o_freq_idx), 15);
      for (int i = 0; i < 3; i++) p_dn();
      #1; chk("idx_dn3", int'(o_freq_idx), 12);
      for (int i = 0; i < 20; i++) p_dn();
      #1; chk("idx_sat_lo", int'(o_freq_idx), 0);
      for (int i = 0; i < 5; i++) p_up();
      drive(0, 1, 0, 0, 0); drive(0, 1, 1, 1, 0);
      #1; chk("idx_up_dn_cancel", int'(o_freq_idx), 5);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 0);
      drive(0, 1, 1, 1, 0);
      #1; chk("idx_held_up", int'(o_freq_idx), 6);

      // Mode wrap and shapes on a held phase.
      drive(1, 1, 1, 1, 0);
      for (int i = 0; i < 5; i++) p_mode();
      #1; chk("mode_5_pulses", int'(o_wave_sel), 1);
      drive(1, 1, 1, 1, 0);
      cur_en = 1; idle(127 * 64);
      cur_en = 0; p_mode(); p_mode(); idle(2);
      #1; chk("tri_7f", int'(o_sample), 8'hFE);
      cur_en = 1; idle(64);
      cur_en = 0; idle(2);
      #1; chk("tri_80", int'(o_sample), 8'hFF);
      for (int i = 0; i < 3; i++) p_mode();
      idle(2);
      #1; chk("square_80", int'(o_sample), 8'hFF);

      // Disabled window with a mode pulse in the middle.
      nw = 0;
      for (int i = 0; i < 100; i++) begin
         drive(0, (i == 50) ? 1'b0 : 1'b1, 1, 1, 0);
         #1;
         if (o_wrap) nw++;
      end
      chk("hold_no_wrap", nw, 0);

      // Reset mid-ramp with a coincident up press.
      cur_en = 1; p_up(); idle(300);
      drive(1, 1, 0, 1, 1);
      #1;
      chk("midrst_idx", int'(o_freq_idx), 0);
      chk("midrst_sample", int'(o_sample), 0);
      chk("midrst_wave", int'(o_wave_sel), 0);
      drive(0, 1, 1, 1, 1);
      #1; chk("midrst_idx_after", int'(o_freq_idx), 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 200) == 0,
               ($urandom % 6) != 0,
               ($urandom % 5) != 0,
               ($urandom % 7) != 0,
               ($urandom % 8) != 0);
      end
      idle(1);
      #2;
      chk("sb_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
